pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 The block SHALL have parameter AW, default 13, meaning program-counter and target address width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of return-stack entries (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port en  input  1  advance strobe; op is executed only in cycles where en=1.
REQ-006 The block SHALL have port op  input  3  operation: 000 NEXT, 001 JMP, 010 BRC, 011 CALL, 100 RET, 101-111 HOLD.
REQ-007 The block SHALL have port target  input  AW  selected jump/call address.
REQ-008 The block SHALL have port cond  input  1  branch condition for BRC.
REQ-009 The block SHALL have port clr_err  input  1  synchronous clear of the error flags.
REQ-010 The block SHALL have port pc  output  AW  current program counter (registered).
REQ-011 The block SHALL have port sp  output  $clog2(DEPTH)+1  number of occupied stack entries (registered).
REQ-012 The block SHALL have ports stk_full and stk_empty  output  1 each  sp==DEPTH and sp==0, combinational from sp.
REQ-013 The block SHALL have ports err_ovf and err_unf  output  1 each  sticky overflow/underflow flags (registered).

Function
REQ-014 The block SHALL update pc, sp and stack contents one clock edge after the cycle in which en=1 and op are sampled (latency 1, throughput 1 op/cycle).
REQ-015 With en=0, or op in 101-111, the block SHALL hold pc, sp, stack contents.
REQ-016 NEXT SHALL set pc <= pc+1 modulo 2^AW (2^AW-1 wraps to 0).
REQ-017 JMP SHALL set pc <= target.
REQ-018 BRC SHALL set pc <= target when cond=1, else pc <= pc+1 modulo 2^AW.
REQ-019 CALL with stk_full=0 SHALL write pc+1 (modulo 2^AW) to entry sp, set sp <= sp+1, pc <= target.
REQ-020 CALL with stk_full=1 SHALL leave pc, sp and stack unchanged and set err_ovf <= 1.
REQ-021 RET with stk_empty=0 SHALL set pc <= entry sp-1 and sp <= sp-1 (LIFO order).
REQ-022 RET with stk_empty=1 SHALL leave pc and sp unchanged and set err_unf <= 1.
REQ-023 err_ovf/err_unf SHALL remain 1 until clr_err=1 is sampled; if clr_err and a new error occur in the same cycle, the flag SHALL end at 1 (set wins).
REQ-024 clr_err SHALL act independently of en and SHALL NOT affect pc, sp or stack.
REQ-025 Stack entries above sp SHALL be don't-care; no read path SHALL expose them.

Reset
REQ-026 On rst_n=0 the block SHALL immediately (asynchronously) force pc=0, sp=0, err_ovf=0, err_unf=0, hence stk_empty=1, stk_full=0.
REQ-027 Reset asserted mid-sequence (e.g. between CALL and RET) SHALL discard all stacked addresses; a RET after release SHALL raise err_unf.
REQ-028 Stack entry storage SHALL NOT require reset; after release the first op is honoured on the first rising edge with rst_n=1.

Verification
REQ-029 Reset release, 3 cycles en=1 op=NEXT -> pc 0,1,2,3; sp=0; stk_empty=1.
REQ-030 pc=0x0005, CALL target=0x0100, then CALL target=0x0200, then RET, RET -> pc 0x0100, 0x0200, 0x0101, 0x0006; sp 1,2,1,0.
REQ-031 DEPTH=8: nine consecutive CALLs target=0x0010 -> sp=8 and stk_full=1 after eighth; ninth leaves pc=0x0010, sp=8, err_ovf=1; clr_err next cycle -> err_ovf=0.
REQ-032 sp=0, RET -> pc unchanged, err_unf=1; same cycle clr_err=1 with another RET -> err_unf stays 1.
REQ-033 pc=0x1FFF: NEXT -> pc=0x0000; pc=0x1FFF CALL target=0x0040 -> pushed 0x0000, later RET -> pc=0x0000.
REQ-034 pc=0x0020, BRC target=0x0300 cond=0 -> pc=0x0021; cond=1 -> pc=0x0300; en=0 with op=JMP -> pc unchanged; rst_n pulse low mid-cycle after two CALLs -> pc=0, sp=0 without clock edge.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with a LIFO return-address stack for CALL/RET.
// Overflow and underflow are reported through sticky error flags.
module pc_stack #(
  parameter int AW    = 13,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [2:0]               op,
  input  logic [AW-1:0]            target,
  input  logic                     cond,
  input  logic                     clr_err,
  output logic [AW-1:0]            pc,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     stk_full,
  output logic                     stk_empty,
  output logic                     err_ovf,
  output logic                     err_unf
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SPW = PW + 1;

  localparam logic [2:0]     OP_NEXT = 3'b000;
  localparam logic [2:0]     OP_JMP  = 3'b001;
  localparam logic [2:0]     OP_BRC  = 3'b010;
  localparam logic [2:0]     OP_CALL = 3'b011;
  localparam logic [2:0]     OP_RET  = 3'b100;
  localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
  localparam logic [SPW-1:0] SP_MAX  = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ZERO = {SPW{1'b0}};
  localparam logic [AW-1:0]  PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0]  pc_r;
  logic [SPW-1:0] sp_r;
  logic           err_ovf_r;
  logic           err_unf_r;
  logic [AW-1:0]  mem_r [DEPTH];

  logic [AW-1:0]  pc_nxt_s;
  logic [SPW-1:0] sp_nxt_s;
  logic [AW-1:0]  pc_inc_s;
  logic [SPW-1:0] sp_dec_s;
  logic [AW-1:0]  ret_addr_s;
  logic           push_s;
  logic           ovf_set_s;
  logic           unf_set_s;
  logic           full_s;
  logic           empty_s;

  assign full_s     = (sp_r == SP_MAX);
  assign empty_s    = (sp_r == SP_ZERO);
  assign pc_inc_s   = pc_r + PC_ONE;
  assign sp_dec_s   = sp_r - SP_ONE;
  // Only read below sp, so entries above it are never observable.
  assign ret_addr_s = mem_r[sp_dec_s[PW-1:0]];

  // Decode the operation into next pc/sp, a push strobe and error sets.
  always_comb begin
    pc_nxt_s  = pc_r;
    sp_nxt_s  = sp_r;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (en) begin
      case (op)
        OP_NEXT: pc_nxt_s = pc_inc_s;
        OP_JMP:  pc_nxt_s = target;
        OP_BRC: begin
          if (cond) begin
            pc_nxt_s = target;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
        end
        OP_CALL: begin
          if (!full_s) begin
            push_s   = 1'b1;
            sp_nxt_s = sp_r + SP_ONE;
            pc_nxt_s = target;
          end else begin
            ovf_set_s = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty_s) begin
            sp_nxt_s = sp_dec_s;
            pc_nxt_s = ret_addr_s;
          end else begin
            unf_set_s = 1'b1;
          end
        end
        default: pc_nxt_s = pc_r;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Architectural state; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= {AW{1'b0}};
      sp_r      <= SP_ZERO;
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      pc_r      <= pc_nxt_s;
      sp_r      <= sp_nxt_s;
      err_ovf_r <= ovf_set_s | (err_ovf_r & ~clr_err);
      err_unf_r <= unf_set_s | (err_unf_r & ~clr_err);
    end
  end

  // Return-address storage carries no reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[sp_r[PW-1:0]] <= pc_inc_s;
    end
  end

  assign pc        = pc_r;
  assign sp        = sp_r;
  assign stk_full  = full_s;
  assign stk_empty = empty_s;
  assign err_ovf   = err_ovf_r;
  assign err_unf   = err_unf_r;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed vector table, reset corner
// cases and randomized ops checked against a queue-based reference model.
module tb_pc_stack;

  localparam int AW    = 13;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic          cond;
  logic          clr_err;
  logic [AW-1:0] pc;
  logic [3:0]    sp;
  logic          stk_full;
  logic          stk_empty;
  logic          err_ovf;
  logic          err_unf;

  int checks = 0;
  int errors = 0;

  pc_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target),
    .cond(cond), .clr_err(clr_err), .pc(pc), .sp(sp),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic          cond;
    logic          clr;
    logic [AW-1:0] pc;
    int            sp;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic e, input logic [2:0] o,
                              input logic [AW-1:0] t, input logic c,
                              input logic cl, input logic [AW-1:0] p,
                              input int s, input logic ov, input logic un);
    vec_t v;
    v.en = e; v.op = o; v.target = t; v.cond = c; v.clr = cl;
    v.pc = p; v.sp = s; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int epc, input int esp,
                           input bit eovf, input bit eunf);
    check({tag, " pc"}, 32'(pc), 32'(epc));
    check({tag, " sp"}, 32'(sp), 32'(esp));
    check({tag, " full"}, 32'(stk_full), 32'(esp == DEPTH));
    check({tag, " empty"}, 32'(stk_empty), 32'(esp == 0));
    check({tag, " ovf"}, 32'(err_ovf), 32'(eovf));
    check({tag, " unf"}, 32'(err_unf), 32'(eunf));
  endtask

  task automatic step(input logic e, input logic [2:0] o,
                      input logic [AW-1:0] t, input logic c, input logic cl);
    en = e; op = o; target = t; cond = c; clr_err = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; op = 3'b000; target = '0; cond = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  initial begin
    // reset state is visible without any clock edge
    rst_n = 1'b0; en = 1'b0; op = 3'b000; target = '0; cond = 1'b0; clr_err = 1'b0;
    #1;
    check_all("reset", 0, 0, 1'b0, 1'b0);
    do_reset();

    add(1, 3'b000, 13'h0000, 0, 0, 13'h0001, 0, 0, 0);
    add(1, 3'b000, 13'h0000, 0, 0, 13'h0002, 0, 0, 0);
    add(1, 3'b000, 13'h0000, 0, 0, 13'h0003, 0, 0, 0);
    add(1, 3'b000, 13'h0000, 0, 0, 13'h0004, 0, 0, 0);
    add(1, 3'b000, 13'h0000, 0, 0, 13'h0005, 0, 0, 0);
    add(1, 3'b011, 13'h0100, 0, 0, 13'h0100, 1, 0, 0);
    add(1, 3'b011, 13'h0200, 0, 0, 13'h0200, 2, 0, 0);
    add(1, 3'b100, 13'h0000, 0, 0, 13'h0101, 1, 0, 0);
    add(1, 3'b100, 13'h0000, 0, 0, 13'h0006, 0, 0, 0);
    add(1, 3'b100, 13'h0000, 0, 0, 13'h0006, 0, 0, 1);
    add(1, 3'b100, 13'h0000, 0, 1, 13'h0006, 0, 0, 1);
    add(0, 3'b100, 13'h0000, 0, 1, 13'h0006, 0, 0, 0);
    add(1, 3'b001, 13'h0020, 0, 0, 13'h0020, 0, 0, 0);
    add(1, 3'b010, 13'h0300, 0, 0, 13'h0021, 0, 0, 0);
    add(1, 3'b001, 13'h0020, 0, 0, 13'h0020, 0, 0, 0);
    add(1, 3'b010, 13'h0300, 1, 0, 13'h0300, 0, 0, 0);
    add(0, 3'b001, 13'h0555, 1, 0, 13'h0300, 0, 0, 0);
    add(1, 3'b101, 13'h0555, 1, 0, 13'h0300, 0, 0, 0);
    add(1, 3'b110, 13'h0555, 1, 0, 13'h0300, 0, 0, 0);
    add(1, 3'b111, 13'h0555, 1, 0, 13'h0300, 0, 0, 0);
    add(1, 3'b001, 13'h1FFF, 0, 0, 13'h1FFF, 0, 0, 0);
    add(1, 3'b000, 13'h0000, 0, 0, 13'h0000, 0, 0, 0);
    add(1, 3'b001, 13'h1FFF, 0, 0, 13'h1FFF, 0, 0, 0);
    add(1, 3'b011, 13'h0040, 0, 0, 13'h0040, 1, 0, 0);
    add(1, 3'b100, 13'h0000, 0, 0, 13'h0000, 0, 0, 0);
    add(1, 3'b001, 13'h0010, 0, 0, 13'h0010, 0, 0, 0);
    for (int k = 1; k <= DEPTH; k++) add(1, 3'b011, 13'h0010, 0, 0, 13'h0010, k, 0, 0);
    add(1, 3'b011, 13'h0010, 0, 0, 13'h0010, 8, 1, 0);
    add(0, 3'b000, 13'h0000, 0, 1, 13'h0010, 8, 0, 0);
    add(1, 3'b100, 13'h0000, 0, 0, 13'h0011, 7, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].op, vecs[i].target, vecs[i].cond, vecs[i].clr);
      check_all($sformatf("vec%0d", i), int'(vecs[i].pc), vecs[i].sp,
                vecs[i].ovf, vecs[i].unf);
    end

    // asynchronous reset between CALL and RET discards the stack
    do_reset();
    step(1, 3'b011, 13'h0123, 0, 0);
    check_all("mid call1", 'h123, 1, 1'b0, 1'b0);
    step(1, 3'b011, 13'h0234, 0, 0);
    check_all("mid call2", 'h234, 2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all("async rst", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 3'b100, 13'h0000, 0, 0);
    check_all("ret after rst", 0, 0, 1'b0, 1'b1);
    step(1, 3'b000, 13'h0000, 0, 1);
    check_all("next after rst", 1, 0, 1'b0, 1'b0);

    // randomized ops against the queue model
    do_reset();
    m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 1500; i++) begin
      logic          r_en, r_cond, r_clr;
      logic [2:0]    r_op;
      logic [AW-1:0] r_tgt;
      r_en   = ($urandom_range(0, 4) != 0);
      r_op   = 3'($urandom_range(0, 7));
      r_tgt  = ($urandom_range(0, 9) == 0) ? 13'h1FFF : AW'($urandom_range(0, 8191));
      r_cond = 1'($urandom_range(0, 1));
      r_clr  = ($urandom_range(0, 11) == 0);
      if (r_clr) begin m_ovf = 0; m_unf = 0; end
      if (r_en) begin
        case (r_op)
          3'd0: m_pc = (m_pc + 1) % 8192;
          3'd1: m_pc = int'(r_tgt);
          3'd2: m_pc = r_cond ? int'(r_tgt) : (m_pc + 1) % 8192;
          3'd3: begin
            if (m_stk.size() < DEPTH) begin
              m_stk.push_back((m_pc + 1) % 8192);
              m_pc = int'(r_tgt);
            end else m_ovf = 1;
          end
          3'd4: begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_unf = 1;
          end
          default: ;
        endcase
      end
      step(r_en, r_op, r_tgt, r_cond, r_clr);
      check_all($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_ovf, m_unf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
